// File: rtl/apb_cmd_master_pkg.sv
// Shared types for the APB command master: FSM states and response status.
package apb_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    RSP_OK,
    RSP_SLVERR,
    RSP_TIMEOUT
  } rsp_status_t;

  // A timeout takes precedence over any error flag, which is unqualified when PREADY is low.
  function automatic rsp_status_t rsp_status(input logic timed_out, input logic slverr);
    if (timed_out) return RSP_TIMEOUT;
    if (slverr) return RSP_SLVERR;
    return RSP_OK;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB3 bus; master = initiator side, slave = requester/peripheral side.
interface apb_cmd_master_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_cmd_master_timeout_cnt.sv
// Saturating ACCESS wait-state counter; expired is high while the count sits at TIMEOUT.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  assign w_at_limit = (r_count == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !w_at_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

  // TIMEOUT of zero means wait forever.
  assign expired = (TIMEOUT != 0) && w_at_limit;
endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 initiator: one command in, one SETUP/ACCESS transfer, one response out.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic              PCLK,
  input  logic              RESET,
  apb_cmd_master_if.master  bus
);
  state_t                r_state;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_rsp_timeout;

  logic        w_clear;
  logic        w_enable;
  logic        w_expired;
  logic        w_done;
  rsp_status_t w_status;

  // Clearing during SETUP makes the count read zero on the first ACCESS cycle.
  assign w_clear  = (r_state == ST_SETUP);
  assign w_enable = (r_state == ST_ACCESS) && !bus.PREADY;
  assign w_done   = bus.PREADY || w_expired;
  assign w_status = rsp_status(!bus.PREADY, bus.PSLVERR);

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (PCLK),
    .rst     (RESET),
    .clear   (w_clear),
    .enable  (w_enable),
    .expired (w_expired)
  );

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= ST_IDLE;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_wdata;
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_done) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= (w_status != RSP_OK);
            r_rsp_timeout <= (w_status == RSP_TIMEOUT);
            r_rsp_rdata   <= (r_pwrite || w_status == RSP_TIMEOUT) ? '0 : bus.PRDATA;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Response fields return to zero so IDLE presents a quiet response port.
          if (bus.rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (r_state == ST_IDLE);
  assign bus.PSEL        = r_psel;
  assign bus.PENABLE     = r_penable;
  assign bus.PWRITE      = r_pwrite;
  assign bus.PADDR       = r_paddr;
  assign bus.PWDATA      = r_pwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master (TIMEOUT = 4); cycle k is observed 1 ns after the k-th edge past accept.
module tb_apb_cmd_master;
  logic PCLK;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  apb_cmd_master_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  apb_cmd_master #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (32),
    .TIMEOUT    (4)
  ) dut (
    .PCLK  (PCLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
  endtask

  task automatic handshake(input string name);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({name, "_rsp_cleared"}, bus.rsp_valid, 1'b0);
    check({name, "_back_idle"}, bus.cmd_ready, 1'b1);
    $display("txn %s rdata=0x%0h err=%0b timeout=%0b", name, dut.r_rsp_rdata, dut.r_rsp_err, dut.r_rsp_timeout);
  endtask

  initial begin
    RESET         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    repeat (2) tick();
    check("rst_psel", bus.PSEL, 1'b0);
    check("rst_penable", bus.PENABLE, 1'b0);
    check("rst_pwrite", bus.PWRITE, 1'b0);
    check("rst_paddr", bus.PADDR, 32'h0);
    check("rst_pwdata", bus.PWDATA, 32'h0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    RESET = 1'b0;
    tick();

    // Zero-wait write
    bus.PREADY = 1'b1;
    send(1'b1, 12'h004, 32'h0000_00A5);
    check("w0_c0_cmd_ready", bus.cmd_ready, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    check("w0_c1_psel", bus.PSEL, 1'b1);
    check("w0_c1_penable", bus.PENABLE, 1'b0);
    check("w0_c1_paddr", bus.PADDR, 32'h004);
    check("w0_c1_pwdata", bus.PWDATA, 32'hA5);
    check("w0_c1_pwrite", bus.PWRITE, 1'b1);
    check("w0_c1_cmd_ready", bus.cmd_ready, 1'b0);
    tick();
    check("w0_c2_psel", bus.PSEL, 1'b1);
    check("w0_c2_penable", bus.PENABLE, 1'b1);
    check("w0_c2_paddr", bus.PADDR, 32'h004);
    check("w0_c2_pwdata", bus.PWDATA, 32'hA5);
    check("w0_c2_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    check("w0_c3_rsp_valid", bus.rsp_valid, 1'b1);
    check("w0_c3_err", bus.rsp_err, 1'b0);
    check("w0_c3_rdata", bus.rsp_rdata, 32'h0);
    check("w0_c3_timeout", bus.rsp_timeout, 1'b0);
    check("w0_c3_psel", bus.PSEL, 1'b0);
    check("w0_c3_penable", bus.PENABLE, 1'b0);
    check("w0_c3_cmd_ready", bus.cmd_ready, 1'b0);
    handshake("write0");

    // Read with 3 wait states; PRDATA junk while PREADY is low
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hDEAD_BEEF;
    send(1'b0, 12'h000, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    check("r3_c1_penable", bus.PENABLE, 1'b0);
    repeat (3) tick();
    check("r3_c4_penable", bus.PENABLE, 1'b1);
    check("r3_c4_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h0000_005A;
    check("r3_c5_psel", bus.PSEL, 1'b1);
    check("r3_c5_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    check("r3_c6_rsp_valid", bus.rsp_valid, 1'b1);
    check("r3_c6_rdata", bus.rsp_rdata, 32'h5A);
    check("r3_c6_err", bus.rsp_err, 1'b0);
    check("r3_c6_psel", bus.PSEL, 1'b0);
    handshake("read_wait3");

    // Slave error on completion
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'h33;
    send(1'b0, 12'h010, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (2) tick();
    check("se_c3_rsp_valid", bus.rsp_valid, 1'b1);
    check("se_c3_err", bus.rsp_err, 1'b1);
    check("se_c3_timeout", bus.rsp_timeout, 1'b0);
    check("se_c3_rdata", bus.rsp_rdata, 32'h33);
    handshake("slverr");

    // PSLVERR on a wait cycle only is ignored
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b1;
    send(1'b0, 12'h014, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (2) tick();
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = 32'h44;
    tick();
    check("sw_c4_rsp_valid", bus.rsp_valid, 1'b1);
    check("sw_c4_err", bus.rsp_err, 1'b0);
    check("sw_c4_rdata", bus.rsp_rdata, 32'h44);
    handshake("slverr_wait_only");

    // Timeout: PREADY stuck low, abort after 4 counted wait cycles
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hFF;
    send(1'b0, 12'h020, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (5) tick();
    check("to_c6_psel", bus.PSEL, 1'b1);
    check("to_c6_penable", bus.PENABLE, 1'b1);
    check("to_c6_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    check("to_c7_psel", bus.PSEL, 1'b0);
    check("to_c7_rsp_valid", bus.rsp_valid, 1'b1);
    check("to_c7_err", bus.rsp_err, 1'b1);
    check("to_c7_timeout", bus.rsp_timeout, 1'b1);
    check("to_c7_rdata", bus.rsp_rdata, 32'h0);
    handshake("timeout");

    // PREADY arrives on the cycle the count reaches TIMEOUT: normal completion
    send(1'b0, 12'h024, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (5) tick();
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h77;
    check("pw_c6_psel", bus.PSEL, 1'b1);
    tick();
    check("pw_c7_rsp_valid", bus.rsp_valid, 1'b1);
    check("pw_c7_err", bus.rsp_err, 1'b0);
    check("pw_c7_timeout", bus.rsp_timeout, 1'b0);
    check("pw_c7_rdata", bus.rsp_rdata, 32'h77);
    handshake("pready_wins");

    // Response backpressure with a new command pending
    send(1'b1, 12'h008, 32'h11);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (2) tick();
    send(1'b1, 12'h00C, 32'h22);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", bus.rsp_valid, 1'b1);
      check("bp_cmd_ready", bus.cmd_ready, 1'b0);
      check("bp_psel", bus.PSEL, 1'b0);
      check("bp_err", bus.rsp_err, 1'b0);
      check("bp_rdata", bus.rsp_rdata, 32'h0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    check("bp_c8_rsp_valid", bus.rsp_valid, 1'b1);
    tick();
    bus.rsp_ready = 1'b0;
    check("bp_c9_cmd_ready", bus.cmd_ready, 1'b1);
    check("bp_c9_psel", bus.PSEL, 1'b0);
    check("bp_c9_rsp_valid", bus.rsp_valid, 1'b0);
    $display("txn backpressure_first responded");
    tick();
    bus.cmd_valid = 1'b0;
    check("bp_c10_psel", bus.PSEL, 1'b1);
    check("bp_c10_paddr", bus.PADDR, 32'h00C);
    check("bp_c10_pwdata", bus.PWDATA, 32'h22);
    repeat (2) tick();
    check("bp_c12_rsp_valid", bus.rsp_valid, 1'b1);
    handshake("backpressure_second");

    // Reset asserted in the middle of ACCESS
    bus.PREADY = 1'b0;
    send(1'b0, 12'h030, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("ra_c2_penable", bus.PENABLE, 1'b1);
    #2;
    RESET = 1'b1;
    #1;
    check("ra_async_psel", bus.PSEL, 1'b0);
    check("ra_async_penable", bus.PENABLE, 1'b0);
    check("ra_async_paddr", bus.PADDR, 32'h0);
    check("ra_async_rsp_valid", bus.rsp_valid, 1'b0);
    repeat (2) tick();
    check("ra_held_rsp_valid", bus.rsp_valid, 1'b0);
    RESET = 1'b0;
    tick();
    check("ra_post_rsp_valid", bus.rsp_valid, 1'b0);
    $display("txn reset_in_access dropped");

    bus.PREADY = 1'b1;
    send(1'b1, 12'h004, 32'h0000_00A5);
    tick();
    bus.cmd_valid = 1'b0;
    check("rw_c1_psel", bus.PSEL, 1'b1);
    check("rw_c1_paddr", bus.PADDR, 32'h004);
    tick();
    check("rw_c2_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    check("rw_c3_rsp_valid", bus.rsp_valid, 1'b1);
    check("rw_c3_err", bus.rsp_err, 1'b0);
    handshake("write_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
